// File: rtl/fpga_data_source_pkg.sv
// Shared definitions for the data source and its companion stream sink.
// Holds the register map offsets, command codes, FSM state encodings and
// the geometry of the 32 x 8 packet RAM.
package fpga_data_source_pkg;

    // Avalon-MM register offsets
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_DBG  = 2'd3;

    // Packet RAM geometry
    localparam int RAM_DEPTH = 32;
    localparam int RAM_AW    = 5;

    // CTRL[2:1] command codes
    typedef enum logic [1:0] {
        CMD_READ   = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_STREAM = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_type_e;

    // Controller states, visible in DBG[9:8]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_FETCH = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

endpackage

// File: rtl/fpga_data_source_ram.sv
// fpga_ram32x8: single-port 32 x 8 RAM, synchronous one-cycle read
// (read-before-write), no reset so it maps onto block/distributed RAM.
// Ports: clk, we (write enable), addr, din (write byte), dout (registered read byte).
module fpga_ram32x8
    import fpga_data_source_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);

    logic [7:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/fpga_data_source.sv
// fpga_data_source: Avalon-MM controlled byte source. Software fills a
// 32 x 8 RAM byte by byte, reads single bytes back through STAT, or streams
// RAM[0..LEN] out as one AXI4-Stream packet.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   avs_address         register select (CTRL, STAT, LEN, DBG)
//   avs_chipselect      slave select
//   avs_write_n         write strobe, active-low
//   avs_writedata       write data
//   avs_readdata        combinational read data, zero wait states
//   axis4_m_tdata/tvalid/tlast/tready   byte stream master
module fpga_data_source
    import fpga_data_source_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write_n,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [7:0]  axis4_m_tdata,
    output logic        axis4_m_tvalid,
    output logic        axis4_m_tlast,
    input  logic        axis4_m_tready
);

    state_e            state_reg, state_next;
    logic [31:0]       ctrl_reg;
    logic              busy_reg;
    logic              error_reg;
    logic [7:0]        last_rd_reg;
    logic [RAM_AW-1:0] len_reg;
    logic [7:0]        beat_cnt_reg;
    logic [RAM_AW-1:0] addr_reg;
    logic [7:0]        tdata_reg;
    logic              tvalid_reg;
    logic              tlast_reg;

    logic              cmd_valid;
    cmd_type_e         cmd_type;
    logic [RAM_AW-1:0] ctrl_addr;
    logic              bus_wr, ctrl_wr, len_wr;
    logic              handshake;

    // Strobes produced by the next-state logic
    logic              accept, start_rd, start_stream, cmd_rsvd;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_dout;

    assign cmd_valid = ctrl_reg[0];
    assign cmd_type  = cmd_type_e'(ctrl_reg[2:1]);
    assign ctrl_addr = ctrl_reg[12:8];

    // CTRL and LEN are locked while a command is in flight
    assign bus_wr  = avs_chipselect && !avs_write_n && !busy_reg;
    assign ctrl_wr = bus_wr && (avs_address == REG_CTRL);
    assign len_wr  = bus_wr && (avs_address == REG_LEN);

    assign handshake = (state_reg == ST_SEND) && tvalid_reg && axis4_m_tready;

    fpga_ram32x8 u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ctrl_reg[23:16]),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The RAM address is always steered one step ahead: the read for the
    // next beat is issued on the edge that leaves IDLE or SEND, so FETCH
    // only has to capture ram_dout. This gives a first beat two clocks
    // after the CTRL write and one beat every two clocks afterwards.
    always_comb begin
        state_next   = state_reg;
        ram_addr     = addr_reg;
        ram_we       = 1'b0;
        accept       = 1'b0;
        start_rd     = 1'b0;
        start_stream = 1'b0;
        cmd_rsvd     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ram_addr = ctrl_addr;
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_type)
                        CMD_WRITE: ram_we = 1'b1;
                        CMD_READ: begin
                            start_rd   = 1'b1;
                            state_next = ST_RD;
                        end
                        CMD_STREAM: begin
                            start_stream = 1'b1;
                            ram_addr     = '0;
                            state_next   = ST_FETCH;
                        end
                        CMD_RSVD: cmd_rsvd = 1'b1;
                        default: cmd_rsvd = 1'b1;
                    endcase
                end
            end
            ST_RD:    state_next = ST_IDLE;
            ST_FETCH: state_next = ST_SEND;
            ST_SEND: begin
                if (handshake) begin
                    if (tlast_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_FETCH;
                        ram_addr   = addr_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg     <= '0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b0;
            last_rd_reg  <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            addr_reg     <= '0;
            tdata_reg    <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
        end else begin
            // A fresh bus write takes priority over the FSM consuming the
            // previous command, so back-to-back commands are not lost.
            if (ctrl_wr) begin
                ctrl_reg <= avs_writedata;
            end else begin
                if (accept) begin
                    ctrl_reg[0] <= 1'b0;
                end
                if (ctrl_reg[31]) begin
                    ctrl_reg[31] <= 1'b0;
                end
            end

            if (len_wr) begin
                len_reg <= avs_writedata[RAM_AW-1:0];
            end

            if (start_rd || start_stream) begin
                busy_reg <= 1'b1;
            end else if ((state_reg == ST_RD) || (handshake && tlast_reg)) begin
                busy_reg <= 1'b0;
            end

            if (accept) begin
                error_reg <= cmd_rsvd;
            end

            if (state_reg == ST_RD) begin
                last_rd_reg <= ram_dout;
            end

            if (start_stream) begin
                addr_reg <= '0;
            end else if (handshake && !tlast_reg) begin
                addr_reg <= addr_reg + 1'b1;
            end

            if (state_reg == ST_FETCH) begin
                tdata_reg  <= ram_dout;
                tlast_reg  <= (addr_reg == len_reg);
                tvalid_reg <= 1'b1;
            end else if (handshake) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end

            // Clear beats a concurrent handshake
            if (ctrl_reg[31]) begin
                beat_cnt_reg <= '0;
            end else if (handshake) begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            REG_CTRL: avs_readdata = ctrl_reg;
            REG_STAT: avs_readdata = {16'd0, last_rd_reg, 6'd0, error_reg, busy_reg};
            REG_LEN:  avs_readdata = {27'd0, len_reg};
            REG_DBG:  avs_readdata = {11'd0, addr_reg, 6'd0, state_reg, beat_cnt_reg};
            default:  avs_readdata = '0;
        endcase
    end

    assign axis4_m_tdata  = tdata_reg;
    assign axis4_m_tvalid = tvalid_reg;
    assign axis4_m_tlast  = tlast_reg;

endmodule

// File: tb/tb_fpga_data_source.sv
// Directed self-checking bench for fpga_data_source. Expected stream beats
// are queued when a packet is launched and popped by a monitor that samples
// the AXI4-Stream port on the falling clock edge.
module tb_fpga_data_source;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [7:0]  axis4_m_tdata;
    logic        axis4_m_tvalid;
    logic        axis4_m_tlast;
    logic        axis4_m_tready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_q[$];      // {tlast, tdata}
    int         cyc = 0;
    int         last_hs = 0;
    bit         spacing_on = 0;
    bit         first_beat = 0;
    bit         stall_prev = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    fpga_data_source dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write_n    (avs_write_n),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .axis4_m_tdata  (axis4_m_tdata),
        .axis4_m_tvalid (axis4_m_tvalid),
        .axis4_m_tlast  (axis4_m_tlast),
        .axis4_m_tready (axis4_m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Stream monitor: a beat transfers on the next rising edge when
    // tvalid&tready are seen here.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'd0, axis4_m_tvalid}, 32'd1);
                chk("hold_data", {24'd0, axis4_m_tdata}, {24'd0, prev_data});
                chk("hold_last", {31'd0, axis4_m_tlast}, {31'd0, prev_last});
            end
            if (axis4_m_tvalid && axis4_m_tready) begin
                chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", {24'd0, axis4_m_tdata}, {24'd0, e[7:0]});
                    chk("beat_last", {31'd0, axis4_m_tlast}, {31'd0, e[8]});
                end
                if (spacing_on && !first_beat)
                    chk("beat_spacing", cyc - last_hs, 32'd2);
                first_beat = 0;
                last_hs = cyc;
            end
            stall_prev = axis4_m_tvalid && !axis4_m_tready;
            prev_data  = axis4_m_tdata;
            prev_last  = axis4_m_tlast;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address    = a;
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write_n    = 1'b0;
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        #1;
        d = avs_readdata;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic ram_load(input logic [4:0] a, input logic [7:0] d);
        bus_write(2'd0, {8'h00, d, 3'b000, a, 5'b00000, 2'b01, 1'b1});
        @(posedge clk);
        #1;
    endtask

    // Read-byte command, then STAT must show the byte two clocks later
    task automatic ram_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
        bus_write(2'd0, {19'd0, a, 5'b00000, 2'b00, 1'b1});
        repeat (2) @(posedge clk);
        #1;
        chk_reg(tag, 2'd1, {16'd0, exp, 8'h00});
    endtask

    task automatic start_stream(input logic [4:0] len, input logic clr);
        bus_write(2'd2, {27'd0, len});
        first_beat = 1;
        bus_write(2'd0, {clr, 28'd0, 3'b101});
        @(posedge clk);
        #1;
        chk("tvalid_early", {31'd0, axis4_m_tvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("tvalid_first", {31'd0, axis4_m_tvalid}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        reset_n        = 1'b0;
        avs_address    = 2'd0;
        avs_chipselect = 1'b0;
        avs_write_n    = 1'b1;
        avs_writedata  = '0;
        axis4_m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        chk_reg("rst_ctrl", 2'd0, 32'h0);
        chk_reg("rst_stat", 2'd1, 32'h0);
        chk_reg("rst_len", 2'd2, 32'h0);
        chk_reg("rst_dbg", 2'd3, 32'h0);
        chk("rst_tvalid", {31'd0, axis4_m_tvalid}, 32'd0);

        // Write 0xA5 to RAM[5], read it back through STAT
        bus_write(2'd0, 32'h00A50503);
        repeat (2) @(posedge clk);
        #1;
        bus_write(2'd0, 32'h00000501);
        repeat (2) @(posedge clk);
        #1;
        chk_reg("rd_stat", 2'd1, 32'h0000A500);
        chk_reg("rd_ctrl_consumed", 2'd0, 32'h00000500);

        // Four-beat packet at full rate
        for (int i = 0; i < 4; i++) ram_load(i[4:0], 8'h10 + i[7:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'h10 + i[7:0]});
        spacing_on = 1;
        start_stream(5'd3, 1'b0);
        drain();
        chk_reg("pkt4_stat", 2'd1, 32'h0000A500);
        chk_reg("pkt4_dbg", 2'd3, 32'h00030004);

        // Same packet with tready low for 5 cycles while beat 2 is offered
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'h10 + i[7:0]});
        spacing_on = 0;
        start_stream(5'd3, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            found = axis4_m_tvalid && (axis4_m_tdata == 8'h12);
        end
        chk("stall_reach_beat2", {31'd0, found}, 32'd1);
        axis4_m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", {24'd0, axis4_m_tdata}, 32'h12);
            chk("stall_valid", {31'd0, axis4_m_tvalid}, 32'd1);
            chk("stall_last", {31'd0, axis4_m_tlast}, 32'd0);
            @(posedge clk);
            #1;
        end
        axis4_m_tready = 1'b1;
        drain();
        chk_reg("stall_dbg", 2'd3, 32'h00030004);

        // Full 32-beat packets; 8 of them wrap the beat count to 0
        for (int i = 0; i < 32; i++) ram_load(i[4:0], i[7:0]);
        spacing_on = 1;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 32; i++) exp_q.push_back({i == 31, i[7:0]});
            start_stream(5'd31, p == 0);
            drain();
            chk("pkt32_tvalid_off", {31'd0, axis4_m_tvalid}, 32'd0);
            if (p == 0) chk_reg("pkt32_dbg", 2'd3, 32'h001F0020);
        end
        chk_reg("beat_wrap_dbg", 2'd3, 32'h001F0000);

        // Reserved command: error set, RAM untouched, no stream
        bus_write(2'd0, 32'h00EE0307);
        repeat (2) @(posedge clk);
        #1;
        chk_reg("rsvd_stat", 2'd1, 32'h0000A502);
        chk_reg("rsvd_dbg", 2'd3, 32'h001F0000);
        ram_check("rsvd_ram3", 5'd3, 8'h03);

        // CTRL and LEN writes during streaming are dropped
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, i[7:0]});
        start_stream(5'd3, 1'b1);
        bus_write(2'd0, 32'h00550201);
        bus_write(2'd2, 32'h00000000);
        drain();
        chk_reg("busy_ctrl_kept", 2'd0, 32'h00000004);
        chk_reg("busy_len_kept", 2'd2, 32'h00000003);
        ram_check("busy_ram2", 5'd2, 8'h02);

        // Reset while beat 3 of an 8-beat packet is offered
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, i[7:0]});
        start_stream(5'd7, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            found = axis4_m_tvalid && (axis4_m_tdata == 8'h03);
        end
        chk("rstmid_reach_beat3", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_tvalid", {31'd0, axis4_m_tvalid}, 32'd0);
        chk_reg("rstmid_ctrl", 2'd0, 32'h0);
        chk_reg("rstmid_stat", 2'd1, 32'h0);
        chk_reg("rstmid_len", 2'd2, 32'h0);
        chk_reg("rstmid_dbg", 2'd3, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rstmid_quiet", {31'd0, axis4_m_tvalid}, 32'd0);
        chk_reg("rstmid_idle", 2'd3, 32'h0);
        ram_check("rstmid_ram_kept", 5'd5, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
